// File: rtl/io_uart_bridge_if.sv
// CPU I/O port bundle for io_uart_bridge: port select, write strobe/data,
// combinational read data, interrupt request and halt flag.
interface io_uart_bridge_if;
  logic [8:0]  io_port;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic [15:0] data_in;
  logic        irq;
  logic        halt;

  modport master (
    output io_port,
    output data_out,
    output data_out_valid,
    input  data_in,
    input  irq,
    input  halt
  );

  modport slave (
    input  io_port,
    input  data_out,
    input  data_out_valid,
    output data_in,
    output irq,
    output halt
  );
endinterface

// File: rtl/io_uart_bridge.sv
// Platform I/O block: halt/UART/interrupt ports on the CPU I/O bus with RX/TX FIFOs
// and an 8N1 UART. Define IO_UART_LOOPBACK_EN to add the port 32 TX->RX loopback.
module io_uart_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16
) (
  input  logic           clock,
  input  logic           reset,
  io_uart_bridge_if.slave bus,
  input  logic           uart_rx,
  output logic           uart_tx
);

  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  logic wrPort0, wrPort2, wrPort3, wrPort5;
  assign wrPort0 = bus.data_out_valid && (bus.io_port == 9'd0);
  assign wrPort2 = bus.data_out_valid && (bus.io_port == 9'd2);
  assign wrPort3 = bus.data_out_valid && (bus.io_port == 9'd3);
  assign wrPort5 = bus.data_out_valid && (bus.io_port == 9'd5);

  logic unusedHi;
  assign unusedHi = ^bus.data_out[15:8];

  logic        halt_q, irq_q, rxOverrun_q;
  logic [1:0]  mask_q;

  logic [7:0]      rxMem_q [RX_DEPTH];
  logic [RXAW:0]   rxWr_q, rxRd_q;
  logic [7:0]      txMem_q [TX_DEPTH];
  logic [TXAW:0]   txWr_q, txRd_q;

  logic rxEmpty, rxFull, rxPop, rxPush, rxByteValid;
  logic txEmpty, txFull, txPop, txPush;
  logic [7:0] rxHead, txHead;

  assign rxEmpty = (rxWr_q == rxRd_q);
  assign rxFull  = (rxWr_q[RXAW-1:0] == rxRd_q[RXAW-1:0]) && (rxWr_q[RXAW] != rxRd_q[RXAW]);
  assign txEmpty = (txWr_q == txRd_q);
  assign txFull  = (txWr_q[TXAW-1:0] == txRd_q[TXAW-1:0]) && (txWr_q[TXAW] != txRd_q[TXAW]);
  assign rxHead  = rxMem_q[rxRd_q[RXAW-1:0]];
  assign txHead  = txMem_q[txRd_q[TXAW-1:0]];

  // A same-clock CPU pop frees the slot before the received byte is judged against full.
  assign rxPop  = wrPort2 && !rxEmpty;
  assign rxPush = rxByteValid && (!rxFull || rxPop);
  assign txPush = wrPort3 && !txFull;

  txState_t    txState_q, txState_d;
  logic [15:0] txCnt_q, txCnt_d;
  logic [7:0]  txShift_q, txShift_d;
  logic [2:0]  txBit_q, txBit_d;
  logic        txSer_q, txSer_d;

  rxState_t    rxState_q, rxState_d;
  logic [15:0] rxCnt_q, rxCnt_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic [2:0]  rxBit_q, rxBit_d;
  logic        rxSync1_q, rxSync2_q, rxPrev_q;
  logic        rxSrc;

`ifdef IO_UART_LOOPBACK_EN
  logic loop_q;
  logic wrPort32;
  assign wrPort32 = bus.data_out_valid && (bus.io_port == 9'd32);
  assign rxSrc    = loop_q ? txSer_q : uart_rx;
  assign uart_tx  = loop_q | txSer_q;
`else
  assign rxSrc   = uart_rx;
  assign uart_tx = txSer_q;
`endif

  logic [1:0] irqBits;
  assign irqBits = {!txFull & mask_q[1], !rxEmpty & mask_q[0]};

  logic [15:0] dataIn;
  always_comb begin
    dataIn = '0;
    case (bus.io_port)
      9'd2:    dataIn = {rxEmpty, rxOverrun_q, 6'b0, rxEmpty ? 8'h00 : rxHead};
      9'd3:    dataIn = {15'b0, !txFull};
      9'd4:    dataIn = {14'b0, irqBits};
      9'd5:    dataIn = {14'b0, mask_q};
`ifdef IO_UART_LOOPBACK_EN
      9'd32:   dataIn = {15'b0, loop_q};
`endif
      default: dataIn = '0;
    endcase
  end

  assign bus.data_in = dataIn;
  assign bus.irq     = irq_q;
  assign bus.halt    = halt_q;

  // STOP falls straight into START when another byte is queued, so frames run back-to-back.
  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txShift_d = txShift_q;
    txBit_d   = txBit_q;
    txPop     = 1'b0;
    case (txState_q)
      TX_IDLE: begin
        if (!txEmpty) begin
          txPop     = 1'b1;
          txShift_d = txHead;
          txCnt_d   = BIT_LAST;
          txState_d = TX_START;
        end
      end
      TX_START: begin
        if (txCnt_q == 16'd0) begin
          txCnt_d   = BIT_LAST;
          txBit_d   = 3'd0;
          txState_d = TX_DATA;
        end else begin
          txCnt_d = txCnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (txCnt_q == 16'd0) begin
          txCnt_d = BIT_LAST;
          if (txBit_q == 3'd7) begin
            txState_d = TX_STOP;
          end else begin
            txBit_d   = txBit_q + 3'd1;
            txShift_d = {1'b0, txShift_q[7:1]};
          end
        end else begin
          txCnt_d = txCnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (txCnt_q == 16'd0) begin
          if (!txEmpty) begin
            txPop     = 1'b1;
            txShift_d = txHead;
            txCnt_d   = BIT_LAST;
            txState_d = TX_START;
          end else begin
            txState_d = TX_IDLE;
          end
        end else begin
          txCnt_d = txCnt_q - 16'd1;
        end
      end
      default: txState_d = TX_IDLE;
    endcase
    txSer_d = (txState_d == TX_START) ? 1'b0 :
              (txState_d == TX_DATA)  ? txShift_d[0] : 1'b1;
  end

  // Receiver samples the synchronised line mid-bit; a high start sample is a glitch.
  always_comb begin
    rxState_d   = rxState_q;
    rxCnt_d     = rxCnt_q;
    rxShift_d   = rxShift_q;
    rxBit_d     = rxBit_q;
    rxByteValid = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        if (rxPrev_q && !rxSync2_q) begin
          rxCnt_d   = HALF_LAST;
          rxState_d = RX_START;
        end
      end
      RX_START: begin
        if (rxCnt_q == 16'd0) begin
          if (rxSync2_q) begin
            rxState_d = RX_IDLE;
          end else begin
            rxCnt_d   = BIT_LAST;
            rxBit_d   = 3'd0;
            rxState_d = RX_DATA;
          end
        end else begin
          rxCnt_d = rxCnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rxCnt_q == 16'd0) begin
          rxShift_d = {rxSync2_q, rxShift_q[7:1]};
          rxCnt_d   = BIT_LAST;
          if (rxBit_q == 3'd7) begin
            rxState_d = RX_STOP;
          end else begin
            rxBit_d = rxBit_q + 3'd1;
          end
        end else begin
          rxCnt_d = rxCnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rxCnt_q == 16'd0) begin
          rxByteValid = rxSync2_q;
          rxState_d   = RX_IDLE;
        end else begin
          rxCnt_d = rxCnt_q - 16'd1;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rxPush) rxMem_q[rxWr_q[RXAW-1:0]] <= rxShift_q;
    if (txPush) txMem_q[txWr_q[TXAW-1:0]] <= bus.data_out[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      halt_q      <= 1'b0;
      irq_q       <= 1'b0;
      mask_q      <= 2'b00;
      rxOverrun_q <= 1'b0;
      rxWr_q      <= '0;
      rxRd_q      <= '0;
      txWr_q      <= '0;
      txRd_q      <= '0;
      txState_q   <= TX_IDLE;
      txCnt_q     <= 16'd0;
      txShift_q   <= 8'd0;
      txBit_q     <= 3'd0;
      txSer_q     <= 1'b1;
      rxState_q   <= RX_IDLE;
      rxCnt_q     <= 16'd0;
      rxShift_q   <= 8'd0;
      rxBit_q     <= 3'd0;
      rxSync1_q   <= 1'b1;
      rxSync2_q   <= 1'b1;
      rxPrev_q    <= 1'b1;
`ifdef IO_UART_LOOPBACK_EN
      loop_q      <= 1'b0;
`endif
    end else begin
      halt_q <= halt_q | wrPort0;
      irq_q  <= |irqBits;
      if (wrPort5) mask_q <= bus.data_out[1:0];
      if (wrPort2) rxOverrun_q <= 1'b0;
      if (rxByteValid && rxFull && !rxPop) rxOverrun_q <= 1'b1;
      if (rxPush) rxWr_q <= rxWr_q + 1'b1;
      if (rxPop)  rxRd_q <= rxRd_q + 1'b1;
      if (txPush) txWr_q <= txWr_q + 1'b1;
      if (txPop)  txRd_q <= txRd_q + 1'b1;
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txShift_q <= txShift_d;
      txBit_q   <= txBit_d;
      txSer_q   <= txSer_d;
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxShift_q <= rxShift_d;
      rxBit_q   <= rxBit_d;
      rxSync1_q <= rxSrc;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
`ifdef IO_UART_LOOPBACK_EN
      if (wrPort32) loop_q <= bus.data_out[0];
`endif
    end
  end

endmodule
